// File: rtl/frame_config_if.sv
// Bitstream word channel into the frame config loader.
// Handshake: a word transfers on the rising clock edge where ConfigValid and
// ConfigReady are both high; ConfigWord must be stable while ConfigValid is
// high, and the source may raise or drop ConfigValid at any time.
interface frame_config_if;
  logic [31:0] ConfigWord;
  logic        ConfigValid;
  logic        ConfigReady;

  modport master (
    output ConfigWord,
    output ConfigValid,
    input  ConfigReady
  );

  modport slave (
    input  ConfigWord,
    input  ConfigValid,
    output ConfigReady
  );
endinterface

// File: rtl/frame_config_loader.sv
// Frame configuration loader: finds the sync word in a 32-bit bitstream,
// parses a header per frame, assembles one data word per tile row and then
// pulses a one-hot frame strobe on the addressed column/frame.
module frame_config_loader #(
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 20,
  parameter int          NumRows         = 4,
  parameter int          NumColumns      = 4,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1,
  parameter logic [31:0] DesyncWord      = 32'hFAB0_FAB0
) (
  input  logic                                   UserCLK,
  input  logic                                   resetn,
  frame_config_if.slave                          cfg,
  output logic [NumRows*FrameBitsPerRow-1:0]     FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0]  FrameStrobe,
  output logic                                   Synced,
  output logic                                   Error,
  output logic [15:0]                            FrameCount,
  output logic [1:0]                             DbgState
);

  localparam int STROBE_W = NumColumns * MaxFramesPerCol;
  localparam int IDX_W    = (STROBE_W > 1) ? $clog2(STROBE_W) : 1;
  localparam int ROW_W    = (NumRows > 1) ? $clog2(NumRows) : 1;

  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NumRows - 1);
  localparam logic [7:0]       COL_LIMIT = 8'(NumColumns);
  localparam logic [4:0]       FRM_LIMIT = 5'(MaxFramesPerCol);

  typedef enum logic [1:0] {
    ST_DESYNC = 2'd0,
    ST_SYNCED = 2'd1,
    ST_DATA   = 2'd2,
    ST_STROBE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [FrameBitsPerRow-1:0] r_rows [NumRows];
  logic [ROW_W-1:0]           r_row;
  logic [IDX_W-1:0]           r_idx;
  logic                       r_hdr_bad;
  logic [STROBE_W-1:0]        r_strobe;
  logic                       r_synced;
  logic                       r_error;
  logic [15:0]                r_count;

  logic              w_ready;
  logic              w_accept;
  logic              w_is_sync;
  logic              w_is_desync;
  logic              w_hdr_load;
  logic              w_data_load;
  logic              w_last_row;
  logic              w_fire;
  logic [7:0]        w_hdr_col;
  logic [4:0]        w_hdr_frm;
  logic              w_hdr_bad;
  logic [IDX_W-1:0]  w_hdr_idx;
  logic [STROBE_W-1:0] w_onehot;

  assign w_accept    = cfg.ConfigValid & w_ready;
  assign w_is_sync   = (cfg.ConfigWord == SyncWord);
  assign w_is_desync = (cfg.ConfigWord == DesyncWord);
  assign w_last_row  = (r_row == LAST_ROW);

  // Header decode: only col = word[15:8] and frm = word[4:0] matter.
  assign w_hdr_col = cfg.ConfigWord[15:8];
  assign w_hdr_frm = cfg.ConfigWord[4:0];
  assign w_hdr_bad = (w_hdr_col >= COL_LIMIT) || (w_hdr_frm >= FRM_LIMIT);
  assign w_hdr_idx = IDX_W'(w_hdr_col) * IDX_W'(MaxFramesPerCol) + IDX_W'(w_hdr_frm);
  assign w_onehot  = {{(STROBE_W-1){1'b0}}, 1'b1} << r_idx;

  // State register.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) r_state <= ST_DESYNC;
    else         r_state <= w_state_next;
  end

  // Next-state decode from the accepted word and row position.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_DESYNC: begin
        if (w_accept && w_is_sync) w_state_next = ST_SYNCED;
      end
      ST_SYNCED: begin
        if (w_accept) begin
          if (w_is_desync)     w_state_next = ST_DESYNC;
          else if (!w_is_sync) w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_accept && w_last_row) w_state_next = r_hdr_bad ? ST_SYNCED : ST_STROBE;
      end
      ST_STROBE: w_state_next = ST_SYNCED;
      default:   w_state_next = ST_DESYNC;
    endcase
  end

  // Per-state outputs: ready is held low during reset and in the strobe cycle.
  always_comb begin
    w_ready     = 1'b0;
    w_hdr_load  = 1'b0;
    w_data_load = 1'b0;
    w_fire      = 1'b0;
    unique case (r_state)
      ST_DESYNC: w_ready = resetn;
      ST_SYNCED: begin
        w_ready    = resetn;
        w_hdr_load = w_accept & ~w_is_sync & ~w_is_desync;
      end
      ST_DATA: begin
        w_ready     = resetn;
        w_data_load = w_accept;
        w_fire      = w_accept & w_last_row & ~r_hdr_bad;
      end
      ST_STROBE: w_ready = 1'b0;
      default:   w_ready = 1'b0;
    endcase
  end

  // Capture header fields and track which row the next data word fills.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      r_row     <= '0;
      r_idx     <= '0;
      r_hdr_bad <= 1'b0;
    end else if (w_hdr_load) begin
      r_row     <= '0;
      r_idx     <= w_hdr_idx;
      r_hdr_bad <= w_hdr_bad;
    end else if (w_data_load) begin
      r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
    end
  end

  // Row data is written only when a data word is accepted, so it stays stable
  // through the strobe and until the next frame overwrites it.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      r_rows <= '{default: '0};
    end else if (w_data_load) begin
      r_rows[r_row] <= cfg.ConfigWord;
    end
  end

  // One-cycle strobe launched by the edge that accepts the last good row.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn)     r_strobe <= '0;
    else if (w_fire) r_strobe <= w_onehot;
    else             r_strobe <= '0;
  end

  // Frame counter advances together with the strobe.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn)     r_count <= '0;
    else if (w_fire) r_count <= r_count + 16'd1;
  end

  // Sticky error on any out-of-range header.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn)                      r_error <= 1'b0;
    else if (w_hdr_load && w_hdr_bad) r_error <= 1'b1;
  end

  // Synced mirrors the state being entered, so it changes with the state.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) r_synced <= 1'b0;
    else         r_synced <= (w_state_next != ST_DESYNC);
  end

  // Flatten the row registers onto the FrameData bus.
  always_comb begin
    FrameData = '0;
    for (int r = 0; r < NumRows; r++) begin
      FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] = r_rows[r];
    end
  end

  assign cfg.ConfigReady = w_ready;
  assign FrameStrobe     = r_strobe;
  assign Synced          = r_synced;
  assign Error           = r_error;
  assign FrameCount      = r_count;
  assign DbgState        = r_state;

endmodule

// File: tb/tb_frame_config_loader.sv
// Bench for frame_config_loader: directed frames plus randomized traffic,
// with a queue-based reference of the loader's behaviour and a strobe monitor.
module tb_frame_config_loader;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int FRMS = 20;
  localparam int SW   = COLS * FRMS;
  localparam int DW   = ROWS * 32;
  localparam int EW   = 7 + DW;
  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

  // ---------------- clock / reset ----------------
  logic UserCLK = 1'b0;
  logic resetn  = 1'b0;
  always #5 UserCLK = ~UserCLK;

  frame_config_if cfg_if ();
  logic [DW-1:0] FrameData;
  logic [SW-1:0] FrameStrobe;
  logic          Synced;
  logic          Error;
  logic [15:0]   FrameCount;
  logic [1:0]    DbgState;

  frame_config_loader dut (
    .UserCLK     (UserCLK),
    .resetn      (resetn),
    .cfg         (cfg_if),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .Synced      (Synced),
    .Error       (Error),
    .FrameCount  (FrameCount),
    .DbgState    (DbgState)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // ---------------- reference model ----------------
  bit            m_synced;
  bit            m_in_data;
  bit            m_bad;
  bit            m_error;
  int            m_col;
  int            m_frm;
  int            m_count;
  logic [31:0]   m_rows[$];
  logic [DW-1:0] m_fd;
  logic [EW-1:0] exp_q[$];
  bit            exp_now;

  function automatic void model_reset();
    m_synced  = 0;
    m_in_data = 0;
    m_bad     = 0;
    m_error   = 0;
    m_count   = 0;
    m_fd      = '0;
    m_rows.delete();
    exp_q.delete();
    exp_now   = 0;
  endfunction

  function automatic void model_accept(input logic [31:0] w, output bit fired);
    logic [DW-1:0] d;
    fired = 0;
    if (m_in_data) begin
      m_fd[m_rows.size()*32 +: 32] = w;
      m_rows.push_back(w);
      if (m_rows.size() == ROWS) begin
        m_in_data = 0;
        if (!m_bad) begin
          d = '0;
          for (int i = 0; i < ROWS; i++) d[i*32 +: 32] = m_rows[i];
          exp_q.push_back({7'(m_col * FRMS + m_frm), d});
          m_count = (m_count + 1) % 65536;
          fired = 1;
        end
      end
    end else if (!m_synced) begin
      if (w == SYNC) m_synced = 1;
    end else if (w == DESYNC) begin
      m_synced = 0;
    end else if (w != SYNC) begin
      m_col = int'(w[15:8]);
      m_frm = int'(w[4:0]);
      m_bad = (m_col >= COLS) || (m_frm >= FRMS);
      if (m_bad) m_error = 1;
      m_in_data = 1;
      m_rows.delete();
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    @(negedge UserCLK);
    cfg_if.ConfigValid = 1'b0;
    repeat (n) @(negedge UserCLK);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    bit acc;
    bit fired;
    int waited;
    acc    = 0;
    waited = 0;
    repeat (gap) begin
      @(negedge UserCLK);
      cfg_if.ConfigValid = 1'b0;
      cfg_if.ConfigWord  = $urandom;
    end
    while (!acc && waited < 20) begin
      @(negedge UserCLK);
      cfg_if.ConfigWord  = w;
      cfg_if.ConfigValid = 1'b1;
      acc = cfg_if.ConfigReady;
      @(posedge UserCLK);
      waited++;
    end
    if (!acc) begin
      check("accept_timeout", 0, 1);
    end else begin
      model_accept(w, fired);
      if (fired) exp_now = 1;
      #1;
      check("synced", Synced, m_synced);
      check("error", Error, m_error);
      check("frame_data_rows", FrameData, m_fd);
      if (!fired) check("frame_count", FrameCount, m_count);
    end
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [DW-1:0] d, input int gap);
    send_word(hdr, gap);
    for (int i = 0; i < ROWS; i++) send_word(d[i*32 +: 32], gap);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_framedata"}, FrameData, '0);
    check({tag, "_strobe"}, FrameStrobe, '0);
    check({tag, "_synced"}, Synced, 0);
    check({tag, "_error"}, Error, 0);
    check({tag, "_count"}, FrameCount, 0);
    check({tag, "_ready"}, cfg_if.ConfigReady, 0);
  endtask

  task automatic async_reset(input string tag);
    #2;
    resetn = 1'b0;
    cfg_if.ConfigValid = 1'b0;
    #1;
    check_zero_outputs(tag);
    model_reset();
    @(negedge UserCLK);
    #2;
    resetn = 1'b1;
    #1;
    check({tag, "_ready_after"}, cfg_if.ConfigReady, 1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit            mon_hi;
  logic [EW-1:0] mon_e;

  always @(negedge UserCLK) begin
    if (resetn) begin
      mon_hi = (FrameStrobe != '0);
      if (mon_hi || exp_now) begin
        check("strobe_timing", mon_hi, exp_now);
        if (mon_hi) begin
          check("strobe_onehot", $countones(FrameStrobe), 1);
          check("ready_low_in_strobe", cfg_if.ConfigReady, 0);
          check("synced_in_strobe", Synced, 1);
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
          end else begin
            mon_e = exp_q.pop_front();
            check("strobe_bit", FrameStrobe, SW'(1) << mon_e[DW +: 7]);
            check("strobe_frame_data", FrameData, mon_e[DW-1:0]);
          end
        end
      end
      exp_now = 0;
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] hdr;
  logic [DW-1:0] dat;

  initial begin
    cfg_if.ConfigValid = 1'b0;
    cfg_if.ConfigWord  = '0;
    model_reset();

    // Reset held, then released.
    repeat (3) @(negedge UserCLK);
    check_zero_outputs("reset_held");
    #2;
    resetn = 1'b1;
    @(negedge UserCLK);
    check("ready_after_reset", cfg_if.ConfigReady, 1);
    check("synced_after_reset", Synced, 0);
    check("strobe_after_reset", FrameStrobe, '0);

    // Junk word dropped, then sync.
    send_word(32'h1234_5678, 0);
    send_word(SYNC, 0);

    // Good frame col2 frm3 -> bit 43.
    send_frame(32'h0000_0203, 128'h44444444_33333333_22222222_11111111, 0);
    idle(3);
    check("frame1_data", FrameData, 128'h44444444_33333333_22222222_11111111);
    check("frame1_count", FrameCount, 1);

    // Bad header: data consumed, error set, no strobe.
    dat = {$urandom, $urandom, $urandom, $urandom};
    send_frame(32'h0000_0515, dat, 0);
    idle(3);
    check("bad_hdr_error", Error, 1);
    check("bad_hdr_count", FrameCount, 1);
    send_frame(32'h0000_0000, {$urandom, $urandom, $urandom, $urandom}, 1);
    idle(2);

    // Valid gaps, DesyncWord as data row 1, then a real desync.
    send_frame(32'h0000_0113, {32'hAAAA_0003, 32'h5555_0002, DESYNC, 32'h0BAD_F00D}, 3);
    send_word(DESYNC, 2);
    idle(2);
    check("desync_synced", Synced, 0);

    // Randomized traffic.
    for (int it = 0; it < 25; it++) begin
      send_word(SYNC, $urandom_range(0, 2));
      hdr = {16'($urandom), 8'($urandom_range(0, 5)), 3'($urandom), 5'($urandom_range(0, 23))};
      for (int i = 0; i < ROWS; i++) begin
        case ($urandom_range(0, 7))
          0:       dat[i*32 +: 32] = SYNC;
          1:       dat[i*32 +: 32] = DESYNC;
          default: dat[i*32 +: 32] = $urandom;
        endcase
      end
      send_frame(hdr, dat, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        send_word(DESYNC, 0);
        send_word($urandom, $urandom_range(0, 1));
      end
    end
    idle(3);

    // Reset while a strobe is in flight clears it immediately.
    send_word(SYNC, 0);
    send_frame(32'h0000_0302, {$urandom, $urandom, $urandom, $urandom}, 0);
    check("strobe_before_reset", FrameStrobe, SW'(1) << 62);
    async_reset("reset_in_strobe");

    // Reset during DATA after two rows; fresh frame afterwards.
    send_word(SYNC, 0);
    send_word(32'h0000_0101, 0);
    send_word($urandom, 0);
    send_word($urandom, 0);
    @(negedge UserCLK);
    async_reset("reset_in_data");
    send_word(SYNC, 1);
    send_frame(32'h0000_0310, {$urandom, $urandom, $urandom, $urandom}, 0);
    idle(3);
    check("post_reset_count", FrameCount, 1);

    // Final bookkeeping.
    idle(4);
    check("scoreboard_drained", exp_q.size(), 0);
    check("final_count", FrameCount, m_count);
    check("final_error", Error, m_error);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog: the bench must always terminate.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_config_loader.md
Name: frame_config_loader

Overview:
Upstream configuration stage that drives the FrameData/FrameStrobe config ports of every fabric tile, including the CPU IO column.
- Accepts a 32-bit bitstream word stream over a valid/ready handshake and detects the sync word.
- Per frame, parses a header word, assembles one data word per tile row, then fires a single-cycle one-hot strobe on the addressed column/frame.
- Tiles latch FrameData on the strobe.

Parameters:
FrameBitsPerRow, 32, width of one row's frame data word; must equal 32.
MaxFramesPerCol, 20, frame strobes per column.
NumRows, 4, tile rows; data words per frame.
NumColumns, 4, tile columns.
SyncWord, 32'hFAB0_FAB1, enters synced mode.
DesyncWord, 32'hFAB0_FAB0, leaves synced mode.

Ports:
UserCLK  in  1  config clock, rising edge
resetn  in  1  asynchronous active-low reset
ConfigWord  in  32  bitstream word
ConfigValid  in  1  ConfigWord valid
ConfigReady  out  1  loader accepts word this cycle
FrameData  out  NumRows*FrameBitsPerRow  row r occupies bits [32r+31:32r]
FrameStrobe  out  NumColumns*MaxFramesPerCol  column c, frame f at bit c*MaxFramesPerCol+f
Synced  out  1  high while in synced mode
Error  out  1  sticky bad-header flag
FrameCount  out  16  frames successfully strobed, wraps 0xFFFF->0

Behaviour:
- Transfer: a word is accepted on a rising UserCLK edge when ConfigValid && ConfigReady.
- Reset (resetn low, async): state=DESYNC; FrameData=0; FrameStrobe=0; Synced=0; Error=0; FrameCount=0; ConfigReady=0 while reset is held.
- Mid-operation reset:
  - A partially loaded frame is discarded.
  - A strobe in flight is cleared immediately, without waiting for a clock edge.
- State DESYNC: ConfigReady=1.
  - Accepted word == SyncWord -> SYNCED.
  - Any other word is dropped.
- State SYNCED: ConfigReady=1; Synced=1.
  - Accepted DesyncWord -> DESYNC.
  - Accepted SyncWord is ignored.
  - Any other accepted word is a header -> DATA, row index = 0.
- Header fields:
  - col = word[15:8]; frm = word[4:0]; other bits are ignored.
  - Header is bad if col >= NumColumns or frm >= MaxFramesPerCol; a bad header sets Error (sticky until reset).
  - Frame data is still consumed after a bad header, but no strobe is issued.
- State DATA: ConfigReady=1. Every accepted word is data, including sync/desync values.
  - Word k writes FrameData row k.
  - After row NumRows-1 is accepted: if the header was good -> STROBE, else -> SYNCED.
- State STROBE (exactly one cycle): ConfigReady=0.
  - FrameStrobe has exactly one bit high, at col*MaxFramesPerCol+frm; all other bits are 0.
  - FrameCount increments on this cycle.
  - Next state is SYNCED.
- Latency: FrameStrobe is high in the cycle immediately after the edge that accepts the last data word.
- FrameData stability:
  - FrameData rows are registered and change only on data-word acceptance.
  - FrameData is stable across the strobe cycle and until the next frame's data overwrites it.
- FrameStrobe is a registered output; it is never high in DESYNC, SYNCED or DATA.
- Synced is registered from state and is high in SYNCED, DATA and STROBE.
- Valid deasserted mid-frame: the loader waits indefinitely in DATA; there is no timeout.

Test Plan:
- Reset then idle -> all outputs 0, ConfigReady=1 after resetn rises, Synced=0.
- Words 0x12345678, SyncWord -> first word dropped, Synced=1 one cycle after SyncWord accepted.
- Sync; header 0x00000203 (col2, frm3); data 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> FrameData = 0x44444444_33333333_22222222_11111111; FrameStrobe bit 43 high for exactly one cycle, one cycle after the last data word; ConfigReady=0 that cycle; FrameCount=1.
- Sync; header 0x00000515 (col5, frm21, both bad); 4 data words -> Error=1, no strobe bit ever high, returns to SYNCED, FrameCount unchanged; next good frame (col0, frm0) strobes bit 0.
- Sync; header; data words with ConfigValid gaps, including DesyncWord as data row 1 -> DesyncWord loaded into row 1, strobe still issued; a DesyncWord sent afterwards -> Synced=0.
- resetn pulsed low during DATA after 2 data words -> outputs zero asynchronously; after release a fresh sync + full frame strobes correctly with FrameCount=1.
